// File: rtl/ddr_bank_pkg.sv
// ddr_bank_pkg: shared FSM state type and beat-index sizing for the bank burst controller.
package ddr_bank_pkg;
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
    function automatic int beat_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int BEAT_W = beat_w(8);
endpackage

// File: rtl/bank_burst_ctrl.sv
// bank_burst_ctrl: issues one BL-beat wrapped burst per command to a bank and
// reassembles read beats that return RD_LAT cycles after their column was driven.
module bank_burst_ctrl
    import ddr_bank_pkg::*;
#(
    parameter int DEVICE_WIDTH = 4,
    parameter int ROWS         = 131072,
    parameter int COLS         = 1024,
    parameter int BL           = 8,
    parameter int RD_LAT       = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_wr,
    input  logic [$clog2(ROWS)-1:0]      cmd_row,
    input  logic [$clog2(COLS)-1:0]      cmd_col,
    input  logic [DEVICE_WIDTH*BL-1:0]   cmd_wdata,
    output logic [DEVICE_WIDTH*BL-1:0]   rd_data,
    output logic                         rd_valid,
    output logic                         rd_o_wr,
    output logic [$clog2(ROWS)-1:0]      row,
    output logic [$clog2(COLS)-1:0]      column,
    output logic [DEVICE_WIDTH-1:0]      dqin,
    input  logic [DEVICE_WIDTH-1:0]      dqout
);
    localparam int DW  = DEVICE_WIDTH;
    localparam int RW  = $clog2(ROWS);
    localparam int CLW = $clog2(COLS);
    localparam int BW  = beat_w(BL);
    localparam int CW  = beat_w((BL > RD_LAT) ? BL : RD_LAT);
    localparam logic [CLW-1:0] MASK = CLW'(BL - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic [RW-1:0]        lrow_q, lrow_d;
    logic [CLW-1:0]       col_q, col_d;
    logic [DW*BL-1:0]     wdata_q, wdata_d;
    logic                 drive;
    logic                 rd_o_wr_q, rd_o_wr_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CLW-1:0]       column_q, column_d;
    logic [DW-1:0]        dqin_q, dqin_d;
    logic [RD_LAT-1:0]    pv_q;
    logic [RD_LAT-1:0][BW-1:0] pi_q;
    logic [DW*BL-1:0]     rd_data_q;
    logic                 rd_valid_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        lrow_d  = lrow_q;
        col_d   = col_q;
        wdata_d = wdata_q;
        drive   = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = BURST;
                cnt_d   = '0;
                wr_d    = cmd_wr;
                lrow_d  = cmd_row;
                col_d   = cmd_col;
                wdata_d = cmd_wdata;
                drive   = 1'b1;
            end
            BURST: if (cnt_q == CW'(BL - 1)) begin
                state_d = wr_q ? IDLE : DRAIN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                drive = 1'b1;
            end
            DRAIN: if (cnt_q == CW'(RD_LAT - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
        // column wraps inside the BL-aligned block: only the low log2(BL) bits advance
        rd_o_wr_d = drive & wr_d;
        row_d     = drive ? lrow_d : '0;
        column_d  = drive ? ((col_d & ~MASK) | ((col_d + CLW'(cnt_d)) & MASK)) : '0;
        dqin_d    = (drive && wr_d) ? wdata_d[int'(cnt_d)*DW +: DW] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            lrow_q     <= '0;
            col_q      <= '0;
            wdata_q    <= '0;
            rd_o_wr_q  <= 1'b0;
            row_q      <= '0;
            column_q   <= '0;
            dqin_q     <= '0;
            pv_q       <= '0;
            pi_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            lrow_q     <= lrow_d;
            col_q      <= col_d;
            wdata_q    <= wdata_d;
            rd_o_wr_q  <= rd_o_wr_d;
            row_q      <= row_d;
            column_q   <= column_d;
            dqin_q     <= dqin_d;
            pv_q[0]    <= (state_q == BURST) && !wr_q;
            pi_q[0]    <= BW'(cnt_q);
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pi_q[i] <= pi_q[i-1];
            end
            if (pv_q[RD_LAT-1])
                rd_data_q[int'(pi_q[RD_LAT-1])*DW +: DW] <= dqout;
            rd_valid_q <= pv_q[RD_LAT-1] && (pi_q[RD_LAT-1] == BW'(BL - 1));
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_o_wr   = rd_o_wr_q;
    assign row       = row_q;
    assign column    = column_q;
    assign dqin      = dqin_q;
endmodule

// File: tb/tb_bank_burst_ctrl.sv
// tb_bank_burst_ctrl: directed checks of burst issue, read assembly, reset abort and RD_LAT=3.
module tb_bank_burst_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v1, v3, c_wr;
    logic [16:0] c_row;
    logic [9:0]  c_col;
    logic [31:0] c_wd;
    logic        rdy1, rval1, bwr1, rdy3, rval3, bwr3;
    logic [31:0] rdata1, rdata3;
    logic [16:0] brow1, brow3;
    logic [9:0]  bcol1, bcol3;
    logic [3:0]  bdin1, bdout1, bdin3, bdout3;
    logic [3:0]  rp1;
    logic [2:0][3:0] rp3;
    logic [3:0]  mem1 [int];
    logic [3:0]  mem3 [int];
    logic [3:0]  wb [8] = '{4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF, 4'h1};
    logic [9:0]  cseq [8] = '{10'h205, 10'h206, 10'h207, 10'h200, 10'h201, 10'h202, 10'h203, 10'h204};
    logic        seen;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    bank_burst_ctrl #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_wr(c_wr),
        .cmd_row(c_row), .cmd_col(c_col), .cmd_wdata(c_wd), .rd_data(rdata1),
        .rd_valid(rval1), .rd_o_wr(bwr1), .row(brow1), .column(bcol1),
        .dqin(bdin1), .dqout(bdout1)
    );

    bank_burst_ctrl #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_wr(c_wr),
        .cmd_row(c_row), .cmd_col(c_col), .cmd_wdata(c_wd), .rd_data(rdata3),
        .rd_valid(rval3), .rd_o_wr(bwr3), .row(brow3), .column(bcol3),
        .dqin(bdin3), .dqout(bdout3)
    );

    // bank models: unwritten cells read back the low nibble of their column
    always @(posedge clk) begin
        if (bwr1) mem1[int'({brow1, bcol1})] = bdin1;
        rp1 <= mem1.exists(int'({brow1, bcol1})) ? mem1[int'({brow1, bcol1})] : bcol1[3:0];
        if (bwr3) mem3[int'({brow3, bcol3})] = bdin3;
        rp3 <= {rp3[1:0], mem3.exists(int'({brow3, bcol3})) ? mem3[int'({brow3, bcol3})] : bcol3[3:0]};
    end
    assign bdout1 = rp1;
    assign bdout3 = rp3[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        v1 = 0; v3 = 0; c_wr = 0; c_row = '0; c_col = '0; c_wd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", rdy1, 1);
        chk("rst_rowcol", {brow1, bcol1, bdin1, bwr1}, 0);
        chk("rst_rdata", rdata1, 0);
        chk("rst_rvalid", rval1, 0);
        // write row 1 col 0
        c_wr = 1; c_row = 1; c_col = 0; c_wd = 32'h1FDB9753; v1 = 1;
        @(negedge clk);
        v1 = 0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("wr_rw%0d", k), bwr1, 1);
            chk($sformatf("wr_row%0d", k), brow1, 1);
            chk($sformatf("wr_col%0d", k), bcol1, k);
            chk($sformatf("wr_dq%0d", k), bdin1, wb[k]);
            @(negedge clk);
        end
        chk("wr_end_ready", rdy1, 1);
        chk("wr_end_zero", {brow1, bcol1, bdin1, bwr1}, 0);
        chk("wr_no_rvalid", rval1, 0);
        // read back while a write is offered throughout the burst
        c_wr = 0; c_row = 1; c_col = 0; v1 = 1;
        @(negedge clk);
        c_wr = 1; c_row = 3; c_col = 10'h008; c_wd = 32'hFEDCBA98;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rd_ready%0d", k), rdy1, 0);
            chk($sformatf("rd_bank%0d", k), {bwr1, brow1, bcol1, bdin1}, {1'b0, 17'd1, 10'(k), 4'h0});
            chk($sformatf("rd_rval%0d", k), rval1, 0);
            @(negedge clk);
        end
        chk("drain_ready", rdy1, 0);
        chk("drain_zero", {brow1, bcol1, bdin1, bwr1}, 0);
        chk("drain_rval", rval1, 0);
        @(negedge clk);
        chk("rd_valid", rval1, 1);
        chk("rd_data", rdata1, 64'h1FDB9753);
        chk("rd_valid_ready", rdy1, 1);
        @(negedge clk);
        v1 = 0;
        chk("b2b_rval_drop", rval1, 0);
        chk("b2b_wbeat0", {bwr1, brow1, bcol1, bdin1}, {1'b1, 17'd3, 10'h008, 4'h8});
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen |= rval1;
        end
        chk("b2b_no_rvalid", seen, 0);
        chk("b2b_hold", rdata1, 64'h1FDB9753);
        chk("b2b_ready", rdy1, 1);
        // wrapped read of row 2 col 0x205
        c_wr = 0; c_row = 2; c_col = 10'h205; v1 = 1;
        @(negedge clk);
        v1 = 0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("wrap_col%0d", k), bcol1, cseq[k]);
            if (k < 2) chk($sformatf("wrap_hold%0d", k), rdata1, 64'h1FDB9753);
            @(negedge clk);
        end
        @(negedge clk);
        chk("wrap_rval", rval1, 1);
        chk("wrap_data", rdata1, 64'h43210765);
        // reset at beat 3 of a read
        c_row = 1; c_col = 0; v1 = 1;
        @(negedge clk);
        v1 = 0;
        repeat (3) @(negedge clk);
        chk("abort_beat3", {brow1, bcol1}, {17'd1, 10'd3});
        rst = 1'b1;
        #1;
        chk("abort_zero", {bwr1, brow1, bcol1, bdin1}, 0);
        chk("abort_rdata", rdata1, 0);
        chk("abort_rval", rval1, 0);
        chk("abort_ready", rdy1, 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen |= rval1;
        end
        chk("abort_no_rvalid", seen, 0);
        c_col = 2; v1 = 1;
        @(negedge clk);
        v1 = 0;
        repeat (8) @(negedge clk);
        chk("post_rst_early", rval1, 0);
        @(negedge clk);
        chk("post_rst_rval", rval1, 1);
        chk("post_rst_data", rdata1, 64'h531FDB97);
        // RD_LAT = 3 instance
        c_wr = 1; c_row = 4; c_col = 10'h008; c_wd = 32'h13579BDF; v3 = 1;
        @(negedge clk);
        v3 = 0;
        chk("l3_wbeat0", {bwr3, brow3, bcol3, bdin3}, {1'b1, 17'd4, 10'h008, 4'hF});
        repeat (8) @(negedge clk);
        c_wr = 0; c_col = 10'h00A; v3 = 1;
        @(negedge clk);
        v3 = 0;
        repeat (10) @(negedge clk);
        chk("l3_early_rval", rval3, 0);
        chk("l3_drain_ready", rdy3, 0);
        @(negedge clk);
        chk("l3_rval", rval3, 1);
        chk("l3_data", rdata3, 64'hDF13579B);
        chk("l3_ready", rdy3, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
